axil_reg_bridge: RTL and testbench



---
 rtl/axil_reg_bridge_if.sv | 59 +++++
 rtl/axil_reg_bridge.sv | 275 +++++++++++++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite slave channels plus the simple device request/ack bus of the register bridge.
// The slave modport is the bridge's view; master is the view of whatever drives it.
interface axil_reg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_BITS   = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ALIGN      = $clog2(STRB_WIDTH);
  localparam int unsigned INDEX_BITS = ADDR_WIDTH - CMD_BITS - ALIGN;

  logic [ADDR_WIDTH-1:0] awaddr_i;
  logic                  awvalid_i;
  logic                  awready_o;

  logic [DATA_WIDTH-1:0] wdata_i;
  logic [STRB_WIDTH-1:0] wstrb_i;
  logic                  wvalid_i;
  logic                  wready_o;

  logic [1:0]            bresp_o;
  logic                  bvalid_o;
  logic                  bready_i;

  logic [ADDR_WIDTH-1:0] araddr_i;
  logic                  arvalid_i;
  logic                  arready_o;

  logic [DATA_WIDTH-1:0] rdata_o;
  logic [1:0]            rresp_o;
  logic                  rvalid_o;
  logic                  rready_i;

  logic                  dev_req_o;
  logic                  dev_we_o;
  logic [INDEX_BITS-1:0] dev_index_o;
  logic [CMD_BITS-1:0]   dev_cmd_o;
  logic [DATA_WIDTH-1:0] dev_wdata_o;
  logic [STRB_WIDTH-1:0] dev_be_o;
  logic                  dev_ack_i;
  logic                  dev_err_i;
  logic [DATA_WIDTH-1:0] dev_rdata_i;

  modport slave (
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i, dev_ack_i, dev_err_i, dev_rdata_i,
    output awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o,
           rvalid_o, dev_req_o, dev_we_o, dev_index_o, dev_cmd_o, dev_wdata_o,
           dev_be_o
  );

  modport master (
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i, dev_ack_i, dev_err_i, dev_rdata_i,
    input  awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o,
           rvalid_o, dev_req_o, dev_we_o, dev_index_o, dev_cmd_o, dev_wdata_o,
           dev_be_o
  );
endinterface

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns single-beat reads/writes into device request/ack accesses,
// with per-channel holding registers, read/write alternation, decode errors and a timeout.
module axil_reg_bridge #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_BITS   = 8,
  parameter int unsigned DEV_COUNT  = 64,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  axil_reg_bridge_if.slave bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ALIGN      = $clog2(STRB_WIDTH);
  localparam int unsigned INDEX_BITS = ADDR_WIDTH - CMD_BITS - ALIGN;
  localparam int unsigned WADDR_W    = ADDR_WIDTH - ALIGN;
  localparam int unsigned CNT_W      = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  state_e                 state_q, state_d;

  logic                   aw_full_q, aw_full_d;
  logic [WADDR_W-1:0]     aw_addr_q, aw_addr_d;
  logic                   w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]  w_strb_q, w_strb_d;
  logic                   ar_full_q, ar_full_d;
  logic [WADDR_W-1:0]     ar_addr_q, ar_addr_d;

  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   arready_q, arready_d;

  logic                   last_wr_q, last_wr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   dev_req_q, dev_req_d;
  logic                   dev_we_q, dev_we_d;
  logic [INDEX_BITS-1:0]  dev_index_q, dev_index_d;
  logic [CMD_BITS-1:0]    dev_cmd_q, dev_cmd_d;
  logic [DATA_WIDTH-1:0]  dev_wdata_q, dev_wdata_d;
  logic [STRB_WIDTH-1:0]  dev_be_q, dev_be_d;

  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic                   wr_elig_c, rd_elig_c, grant_wr_c, grant_rd_c;
  logic [WADDR_W-1:0]     sel_addr_c;
  logic [INDEX_BITS-1:0]  sel_index_c;
  logic                   sel_decerr_c;
  logic [CNT_W-1:0]       cnt_inc_c;
  logic                   unused_addr_bits;

  // Byte-offset bits within a data word carry no information for the device.
  assign unused_addr_bits = ^{bus.awaddr_i[ALIGN-1:0], bus.araddr_i[ALIGN-1:0]};

  // Arbitration: a tie goes to whichever type was not granted most recently.
  assign wr_elig_c    = aw_full_q && w_full_q;
  assign rd_elig_c    = ar_full_q;
  assign grant_wr_c   = wr_elig_c && (!rd_elig_c || !last_wr_q);
  assign grant_rd_c   = rd_elig_c && !grant_wr_c;
  assign sel_addr_c   = grant_wr_c ? aw_addr_q : ar_addr_q;
  assign sel_index_c  = sel_addr_c[WADDR_W-1:CMD_BITS];
  assign sel_decerr_c = 32'(sel_index_c) >= DEV_COUNT;
  assign cnt_inc_c    = cnt_q + CNT_W'(1);

  // Next-state, holding-register and output logic.
  always_comb begin
    state_d     = state_q;
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    ar_full_d   = ar_full_q;
    ar_addr_d   = ar_addr_q;
    last_wr_d   = last_wr_q;
    cnt_d       = cnt_q;
    dev_req_d   = dev_req_q;
    dev_we_d    = dev_we_q;
    dev_index_d = dev_index_q;
    dev_cmd_d   = dev_cmd_q;
    dev_wdata_d = dev_wdata_q;
    dev_be_d    = dev_be_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;

    if (bus.awvalid_i && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = bus.awaddr_i[ADDR_WIDTH-1:ALIGN];
    end
    if (bus.wvalid_i && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = bus.wdata_i;
      w_strb_d = bus.wstrb_i;
    end
    if (bus.arvalid_i && arready_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = bus.araddr_i[ADDR_WIDTH-1:ALIGN];
    end

    case (state_q)
      IDLE: begin
        if (grant_wr_c || grant_rd_c) begin
          last_wr_d   = grant_wr_c;
          cnt_d       = '0;
          dev_we_d    = grant_wr_c;
          dev_index_d = sel_index_c;
          dev_cmd_d   = sel_addr_c[CMD_BITS-1:0];
          if (grant_wr_c) begin
            aw_full_d   = 1'b0;
            w_full_d    = 1'b0;
            dev_wdata_d = w_data_q;
            dev_be_d    = w_strb_q;
          end else begin
            ar_full_d = 1'b0;
          end
          // Out-of-range index answers at once without touching the device.
          if (sel_decerr_c) begin
            if (grant_wr_c) begin
              bvalid_d = 1'b1;
              bresp_d  = RESP_DECERR;
              state_d  = WR_RESP;
            end else begin
              rvalid_d = 1'b1;
              rresp_d  = RESP_DECERR;
              rdata_d  = '0;
              state_d  = RD_RESP;
            end
          end else begin
            dev_req_d = 1'b1;
            state_d   = grant_wr_c ? WR_REQ : RD_REQ;
          end
        end
      end

      WR_REQ, RD_REQ: begin
        if (bus.dev_ack_i) begin
          dev_req_d = 1'b0;
          if (state_q == WR_REQ) begin
            bvalid_d = 1'b1;
            bresp_d  = bus.dev_err_i ? RESP_SLVERR : RESP_OKAY;
            state_d  = WR_RESP;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = bus.dev_err_i ? RESP_SLVERR : RESP_OKAY;
            rdata_d  = bus.dev_rdata_i;
            state_d  = RD_RESP;
          end
        end else if (cnt_inc_c == CNT_W'(TIMEOUT)) begin
          dev_req_d = 1'b0;
          if (state_q == WR_REQ) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            state_d  = WR_RESP;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            state_d  = RD_RESP;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      WR_RESP: begin
        if (bus.bready_i) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      RD_RESP: begin
        if (bus.rready_i) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
    arready_d = !ar_full_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      ar_full_q   <= 1'b0;
      ar_addr_q   <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      last_wr_q   <= 1'b0;
      cnt_q       <= '0;
      dev_req_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_index_q <= '0;
      dev_cmd_q   <= '0;
      dev_wdata_q <= '0;
      dev_be_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      ar_full_q   <= ar_full_d;
      ar_addr_q   <= ar_addr_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      last_wr_q   <= last_wr_d;
      cnt_q       <= cnt_d;
      dev_req_q   <= dev_req_d;
      dev_we_q    <= dev_we_d;
      dev_index_q <= dev_index_d;
      dev_cmd_q   <= dev_cmd_d;
      dev_wdata_q <= dev_wdata_d;
      dev_be_q    <= dev_be_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.awready_o   = awready_q;
  assign bus.wready_o    = wready_q;
  assign bus.arready_o   = arready_q;
  assign bus.bvalid_o    = bvalid_q;
  assign bus.bresp_o     = bresp_q;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.rresp_o     = rresp_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.dev_req_o   = dev_req_q;
  assign bus.dev_we_o    = dev_we_q;
  assign bus.dev_index_o = dev_index_q;
  assign bus.dev_cmd_o   = dev_cmd_q;
  assign bus.dev_wdata_o = dev_wdata_q;
  assign bus.dev_be_o    = dev_be_q;
endmodule

// File: tb/tb_axil_reg_bridge.sv
// Scoreboard bench for axil_reg_bridge: directed AXI-Lite traffic, a scripted device
// responder, and a monitor that checks device requests and B/R responses in order.
module tb_axil_reg_bridge;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CB = 8;

  typedef struct packed {
    logic        we;
    logic [5:0]  idx;
    logic [7:0]  cmd;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dev_exp_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  dev_exp_t   dev_q[$];
  logic [1:0] b_q[$];
  r_exp_t     r_q[$];

  int   ack_delay    = 0;
  logic ack_en       = 1'b1;
  logic dev_err      = 1'b0;
  int   resp_cyc     = 0;
  int   req_rises    = 0;
  int   req_len      = 0;
  int   last_req_len = 0;
  logic req_prev     = 1'b0;

  always #5 clk = ~clk;

  axil_reg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_BITS(CB)) bus ();

  axil_reg_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CMD_BITS  (CB),
    .DEV_COUNT (8),
    .TIMEOUT   (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [5:0] idx, input logic [7:0] cmd, input logic [31:0] d,
                        input logic [3:0] be, input logic [1:0] resp, input bit issue);
    dev_exp_t e;
    e.we = 1'b1; e.idx = idx; e.cmd = cmd; e.wdata = d; e.be = be;
    if (issue) dev_q.push_back(e);
    b_q.push_back(resp);
  endtask

  task automatic exp_rd(input logic [5:0] idx, input logic [7:0] cmd, input logic [1:0] resp,
                        input logic [31:0] d, input bit issue, input bit answer);
    dev_exp_t e;
    r_exp_t   r;
    e.we = 1'b0; e.idx = idx; e.cmd = cmd; e.wdata = '0; e.be = '0;
    r.resp = resp; r.data = d;
    if (issue) dev_q.push_back(e);
    if (answer) r_q.push_back(r);
  endtask

  task automatic send_aw(input logic [15:0] a);
    int n = 0;
    bus.awaddr_i  = a;
    bus.awvalid_i = 1'b1;
    @(negedge clk);
    while (!bus.awready_o && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.awvalid_i = 1'b0;
    check("aw_accept_timeout", 64'(n >= 50), 64'd0);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.wdata_i  = d;
    bus.wstrb_i  = s;
    bus.wvalid_i = 1'b1;
    @(negedge clk);
    while (!bus.wready_o && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.wvalid_i = 1'b0;
    check("w_accept_timeout", 64'(n >= 50), 64'd0);
  endtask

  task automatic send_ar(input logic [15:0] a);
    int n = 0;
    bus.araddr_i  = a;
    bus.arvalid_i = 1'b1;
    @(negedge clk);
    while (!bus.arready_o && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.arvalid_i = 1'b0;
    check("ar_accept_timeout", 64'(n >= 50), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((dev_q.size() != 0 || b_q.size() != 0 || r_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n >= 200), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Device model: acks after ack_delay extra request cycles, read data derived from the address.
  initial begin
    bus.dev_ack_i   = 1'b0;
    bus.dev_err_i   = 1'b0;
    bus.dev_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.dev_req_o) resp_cyc++; else resp_cyc = 0;
      bus.dev_ack_i   = ack_en && bus.dev_req_o && (resp_cyc == ack_delay + 1);
      bus.dev_err_i   = dev_err;
      bus.dev_rdata_i = {16'hBEEF, 2'b00, bus.dev_index_o, bus.dev_cmd_o};
    end
  end

  // Monitor: each new device request and each B/R handshake is matched against the queues.
  initial begin
    dev_exp_t e;
    logic [1:0] eb;
    r_exp_t er;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_prev = 1'b0;
        req_len  = 0;
      end else begin
        if (bus.dev_req_o) begin
          if (!req_prev) begin
            req_rises++;
            if (dev_q.size() == 0) begin
              check("dev_req_unexpected", 64'(bus.dev_req_o), 64'd0);
            end else begin
              e = dev_q.pop_front();
              check("dev_we", 64'(bus.dev_we_o), 64'(e.we));
              check("dev_index", 64'(bus.dev_index_o), 64'(e.idx));
              check("dev_cmd", 64'(bus.dev_cmd_o), 64'(e.cmd));
              if (e.we) begin
                check("dev_wdata", 64'(bus.dev_wdata_o), 64'(e.wdata));
                check("dev_be", 64'(bus.dev_be_o), 64'(e.be));
              end
            end
          end
          req_len++;
        end else if (req_prev) begin
          last_req_len = req_len;
          req_len = 0;
        end
        req_prev = bus.dev_req_o;

        if (bus.bvalid_o && bus.bready_i) begin
          if (b_q.size() == 0) begin
            check("bvalid_unexpected", 64'(bus.bvalid_o), 64'd0);
          end else begin
            eb = b_q.pop_front();
            check("bresp", 64'(bus.bresp_o), 64'(eb));
          end
        end
        if (bus.rvalid_o && bus.rready_i) begin
          if (r_q.size() == 0) begin
            check("rvalid_unexpected", 64'(bus.rvalid_o), 64'd0);
          end else begin
            er = r_q.pop_front();
            check("rresp", 64'(bus.rresp_o), 64'(er.resp));
            check("rdata", 64'(bus.rdata_o), 64'(er.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   rises0;
    logic seen_rv;

    bus.awaddr_i  = '0; bus.awvalid_i = 1'b0;
    bus.wdata_i   = '0; bus.wstrb_i   = '0; bus.wvalid_i = 1'b0;
    bus.araddr_i  = '0; bus.arvalid_i = 1'b0;
    bus.bready_i  = 1'b1;
    bus.rready_i  = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_awready", 64'(bus.awready_o), 64'd0);
    check("rst_arready", 64'(bus.arready_o), 64'd0);
    check("rst_dev_req", 64'(bus.dev_req_o), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid_o), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_awready", 64'(bus.awready_o), 64'd1);
    check("post_rst_wready", 64'(bus.wready_o), 64'd1);
    check("post_rst_arready", 64'(bus.arready_o), 64'd1);
    check("post_rst_index", 64'(bus.dev_index_o), 64'd0);
    check("post_rst_cmd", 64'(bus.dev_cmd_o), 64'd0);
    check("post_rst_wdata", 64'(bus.dev_wdata_o), 64'd0);
    check("post_rst_be", 64'(bus.dev_be_o), 64'd0);
    check("post_rst_rdata", 64'(bus.rdata_o), 64'd0);
    check("post_rst_bresp", 64'(bus.bresp_o), 64'd0);
    check("post_rst_rresp", 64'(bus.rresp_o), 64'd0);

    // W first, AW three cycles later, ack one cycle after request
    ack_delay = 1;
    exp_wr(6'd1, 8'h02, 32'hDEADBEEF, 4'hF, 2'b00, 1'b1);
    send_w(32'hDEADBEEF, 4'hF);
    repeat (2) begin @(posedge clk); #1; end
    send_aw(16'h0408);
    drain();

    // Best-case write latency, all-zero strobes, highest valid index
    ack_delay = 0;
    exp_wr(6'd7, 8'h04, 32'h12345678, 4'h0, 2'b00, 1'b1);
    fork
      send_aw(16'h1C10);
      send_w(32'h12345678, 4'h0);
    join
    @(negedge clk); check("lat_wr_c1_req", 64'(bus.dev_req_o), 64'd0);
    @(negedge clk); check("lat_wr_c2_req", 64'(bus.dev_req_o), 64'd1);
    @(negedge clk); check("lat_wr_c3_bvalid", 64'(bus.bvalid_o), 64'd1);
    drain();

    // Best-case read latency, device error flag gives SLVERR with captured data
    dev_err = 1'b1;
    exp_rd(6'd3, 8'h08, 2'b10, 32'hBEEF0308, 1'b1, 1'b1);
    send_ar(16'h0C20);
    @(negedge clk); check("lat_rd_c1_req", 64'(bus.dev_req_o), 64'd0);
    @(negedge clk); check("lat_rd_c2_req", 64'(bus.dev_req_o), 64'd1);
    @(negedge clk); check("lat_rd_c3_rvalid", 64'(bus.rvalid_o), 64'd1);
    drain();
    dev_err = 1'b0;

    // Timeout: device never acks
    ack_en = 1'b0;
    exp_rd(6'd0, 8'h01, 2'b10, 32'h0, 1'b1, 1'b1);
    send_ar(16'h0004);
    drain();
    check("timeout_req_len", 64'(last_req_len), 64'd4);
    ack_en = 1'b1;

    // Decode errors: write at index 8, then read at index 63
    rises0 = req_rises;
    exp_wr(6'd8, 8'h00, 32'h11111111, 4'hF, 2'b11, 1'b0);
    fork
      send_aw(16'h2000);
      send_w(32'h11111111, 4'hF);
    join
    drain();
    exp_rd(6'd63, 8'h00, 2'b11, 32'h0, 1'b0, 1'b1);
    send_ar(16'hFC00);
    drain();
    check("decerr_no_req", 64'(req_rises), 64'(rises0));

    // Simultaneous write and read twice: grants alternate W, R, W, R
    exp_wr(6'd3, 8'h11, 32'hA0A0A0A0, 4'h5, 2'b00, 1'b1);
    exp_rd(6'd4, 8'h02, 2'b00, 32'hBEEF0402, 1'b1, 1'b1);
    exp_wr(6'd6, 8'h00, 32'hB1B2B3B4, 4'hF, 2'b00, 1'b1);
    exp_rd(6'd2, 8'hFF, 2'b00, 32'hBEEF02FF, 1'b1, 1'b1);
    fork
      send_aw(16'h0C44);
      send_w(32'hA0A0A0A0, 4'h5);
      send_ar(16'h1008);
    join
    fork
      send_aw(16'h1800);
      send_w(32'hB1B2B3B4, 4'hF);
      send_ar(16'h0BFC);
    join
    drain();

    // B backpressure: response held stable, next write buffered until handshake
    bus.bready_i = 1'b0;
    exp_wr(6'd2, 8'h04, 32'h0BADF00D, 4'h3, 2'b00, 1'b1);
    exp_wr(6'd5, 8'h01, 32'h55AA55AA, 4'hC, 2'b00, 1'b1);
    fork
      send_aw(16'h0810);
      send_w(32'h0BADF00D, 4'h3);
    join
    n = 0;
    while (!bus.bvalid_o && n < 20) begin @(negedge clk); n++; end
    check("stall_bvalid_seen", 64'(bus.bvalid_o), 64'd1);
    @(posedge clk); #1;
    fork
      send_aw(16'h1404);
      send_w(32'h55AA55AA, 4'hC);
    join
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_bvalid", 64'(bus.bvalid_o), 64'd1);
      check("stall_bresp", 64'(bus.bresp_o), 64'd0);
      check("stall_no_req", 64'(bus.dev_req_o), 64'd0);
    end
    @(posedge clk); #1;
    bus.bready_i = 1'b1;
    drain();

    // Reset in the middle of a read request
    ack_en = 1'b0;
    exp_rd(6'd3, 8'h00, 2'b00, 32'h0, 1'b1, 1'b0);
    send_ar(16'h0C00);
    n = 0;
    while (!bus.dev_req_o && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_req_seen", 64'(bus.dev_req_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", 64'(bus.dev_req_o), 64'd0);
    check("rst_mid_arready", 64'(bus.arready_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_awready", 64'(bus.awready_o), 64'd1);
    check("rst_mid_wready", 64'(bus.wready_o), 64'd1);
    check("rst_mid_arready_rel", 64'(bus.arready_o), 64'd1);
    seen_rv = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rvalid_o) seen_rv = 1'b1;
    end
    check("rst_mid_no_rvalid", 64'(seen_rv), 64'd0);
    ack_en = 1'b1;
    @(posedge clk); #1;

    // First tie after reset goes to write
    exp_wr(6'd0, 8'h00, 32'hFFFFFFFF, 4'h8, 2'b00, 1'b1);
    exp_rd(6'd7, 8'hFF, 2'b00, 32'hBEEF07FF, 1'b1, 1'b1);
    fork
      send_aw(16'h0000);
      send_w(32'hFFFFFFFF, 4'h8);
      send_ar(16'h1FFC);
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
